// File: rtl/fetch_pc_unit_pkg.sv
// Shared encodings for the fetch/PC stage: branch-select codes, FSM states, instruction width.
// Optional feature macro used by this slice: FETCH_BRANCH_COUNT_EN.
package fetch_pc_unit_pkg;

  localparam int INSTR_W = 17;

  localparam logic [1:0] BS_NEXT   = 2'b00;
  localparam logic [1:0] BS_COND   = 2'b01;
  localparam logic [1:0] BS_JREG   = 2'b10;
  localparam logic [1:0] BS_JCONST = 2'b11;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    LOAD  = 2'b01,
    EXEC  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC selection and branch-taken detection for the fetch stage.
module fetch_next_pc
  import fetch_pc_unit_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
) (
  input  logic [PC_W-1:0]   pc,
  input  logic [1:0]        bs,
  input  logic              ps,
  input  logic              zero,
  input  logic [DATA_W-1:0] reg_a_data,
  input  logic [DATA_W-1:0] const_data,
  output logic [PC_W-1:0]   pc_plus1,
  output logic [PC_W-1:0]   next_pc,
  output logic              taken
);

  logic [PC_W-1:0] const_t_s;
  logic [PC_W-1:0] rega_t_s;
  logic [PC_W-1:0] rel_target_s;

  assign const_t_s    = PC_W'(const_data);
  assign rega_t_s     = PC_W'(reg_a_data);
  assign pc_plus1     = pc + {{(PC_W-1){1'b0}}, 1'b1};
  // Modulo addition makes a negative offset a backward branch for free.
  assign rel_target_s = pc_plus1 + const_t_s;

  // Select the next PC from the branch-select and condition inputs.
  always_comb begin
    next_pc = pc_plus1;
    case (bs)
      BS_NEXT: begin
        next_pc = pc_plus1;
      end
      BS_COND: begin
        if ((zero ^ ps) == 1'b1) begin
          next_pc = rel_target_s;
        end else begin
          next_pc = pc_plus1;
        end
      end
      BS_JREG: begin
        next_pc = rega_t_s;
      end
      BS_JCONST: begin
        if (ps == 1'b1) begin
          if (zero == 1'b0) begin
            next_pc = rel_target_s;
          end else begin
            next_pc = pc_plus1;
          end
        end else begin
          next_pc = const_t_s;
        end
      end
      default: begin
        next_pc = pc_plus1;
      end
    endcase
  end

  // A branch landing on pc+1 is indistinguishable from fall-through, so it is not "taken".
  assign taken = (next_pc != pc_plus1);

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch/PC stage: FETCH -> LOAD -> EXEC sequencing, IR register and PC update.
// Define FETCH_BRANCH_COUNT_EN to add the saturating branch_count output.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              DATA_W   = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  output logic [PC_W-1:0]    imem_addr,
  output logic               imem_rd,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir,
  output logic               ir_valid,
  input  logic [1:0]         bs,
  input  logic               ps,
  input  logic               zero,
  input  logic [DATA_W-1:0]  reg_a_data,
  input  logic [DATA_W-1:0]  const_data,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    pc_plus1,
  output logic               branch_taken
`ifdef FETCH_BRANCH_COUNT_EN
  ,
  output logic [15:0]        branch_count
`endif
);

  fetch_state_e        state_r;
  fetch_state_e        state_next_s;
  logic [PC_W-1:0]     pc_r;
  logic [INSTR_W-1:0]  ir_r;
  logic                branch_taken_r;
  logic [PC_W-1:0]     next_pc_s;
  logic                taken_s;
  logic                exec_done_s;

  fetch_next_pc #(
    .PC_W  (PC_W),
    .DATA_W(DATA_W)
  ) u_next_pc (
    .pc        (pc_r),
    .bs        (bs),
    .ps        (ps),
    .zero      (zero),
    .reg_a_data(reg_a_data),
    .const_data(const_data),
    .pc_plus1  (pc_plus1),
    .next_pc   (next_pc_s),
    .taken     (taken_s)
  );

  assign exec_done_s = (state_r == EXEC) && (stall == 1'b0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic; stall only matters in EXEC.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      FETCH: begin
        state_next_s = LOAD;
      end
      LOAD: begin
        state_next_s = EXEC;
      end
      EXEC: begin
        if (stall == 1'b1) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = FETCH;
        end
      end
      default: begin
        state_next_s = FETCH;
      end
    endcase
  end

  // PC, IR and branch pulse registers; reset discards any pending PC update.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r           <= RESET_PC;
      ir_r           <= {INSTR_W{1'b0}};
      branch_taken_r <= 1'b0;
    end else begin
      if (state_r == LOAD) begin
        ir_r <= imem_data;
      end else begin
        ir_r <= ir_r;
      end
      if (exec_done_s) begin
        pc_r           <= next_pc_s;
        branch_taken_r <= taken_s;
      end else begin
        pc_r           <= pc_r;
        branch_taken_r <= 1'b0;
      end
    end
  end

`ifdef FETCH_BRANCH_COUNT_EN
  logic [15:0] branch_count_r;

  // Saturating count of taken branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_count_r <= 16'h0000;
    end else if (exec_done_s && taken_s && (branch_count_r != 16'hFFFF)) begin
      branch_count_r <= branch_count_r + 16'h0001;
    end else begin
      branch_count_r <= branch_count_r;
    end
  end

  assign branch_count = branch_count_r;
`endif

  // Strobes are decoded from the state register and forced low while reset is held.
  assign imem_rd      = (state_r == FETCH) && (rst == 1'b0);
  assign ir_valid     = (state_r == EXEC) && (rst == 1'b0);
  assign imem_addr    = pc_r;
  assign pc           = pc_r;
  assign ir           = ir_r;
  assign branch_taken = branch_taken_r;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed branch cases plus randomized instructions
// checked against a plain-arithmetic next-PC model and a bench-side instruction memory.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [7:0]  imem_addr;
  logic        imem_rd;
  logic [16:0] imem_data;
  logic [16:0] ir;
  logic        ir_valid;
  logic [1:0]  bs;
  logic        ps;
  logic        zero;
  logic [7:0]  reg_a_data;
  logic [7:0]  const_data;
  logic [7:0]  pc;
  logic [7:0]  pc_plus1;
  logic        branch_taken;
`ifdef FETCH_BRANCH_COUNT_EN
  logic [15:0] branch_count;
`endif

  fetch_pc_unit #(
    .PC_W    (8),
    .DATA_W  (8),
    .RESET_PC(8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .imem_data   (imem_data),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .bs          (bs),
    .ps          (ps),
    .zero        (zero),
    .reg_a_data  (reg_a_data),
    .const_data  (const_data),
    .pc          (pc),
    .pc_plus1    (pc_plus1),
    .branch_taken(branch_taken)
`ifdef FETCH_BRANCH_COUNT_EN
    ,
    .branch_count(branch_count)
`endif
  );

  typedef struct {
    logic [7:0]  pc;
    logic [16:0] ir;
    logic [7:0]  nxt;
    logic        taken;
    int          nstall;
  } exp_t;

  exp_t        exp_q[$];
  logic [16:0] mem[256];
  logic [7:0]  pc_model;
  int          taken_cnt;
  int          n_checks;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory: data appears the cycle after the read strobe.
  initial imem_data = 17'h00000;
  always @(posedge clk) begin
    if (imem_rd) imem_data <= mem[imem_addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Next-PC rules written directly as modulo-256 arithmetic.
  function automatic void model_next(input int pcv, input int b, input int p, input int z,
                                     input int ra, input int cd,
                                     output logic [7:0] nxt, output logic tk);
    int p1;
    int t;
    p1 = (pcv + 1) % 256;
    if (b == 0) t = p1;
    else if (b == 1) t = ((z ^ p) != 0) ? (pcv + 1 + cd) % 256 : p1;
    else if (b == 2) t = ra;
    else if (p == 1) t = (z == 0) ? (pcv + 1 + cd) % 256 : p1;
    else t = cd;
    nxt = 8'(t);
    tk  = (t != p1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_garbage();
    bs         = 2'($urandom_range(0, 3));
    ps         = 1'($urandom_range(0, 1));
    zero       = 1'($urandom_range(0, 1));
    reg_a_data = 8'($urandom_range(0, 255));
    const_data = 8'($urandom_range(0, 255));
  endtask

  task automatic wait_exec();
    int n;
    n = 0;
    while (!ir_valid && n < 10) begin
      drive_garbage();
      stall = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check("reach_exec", {31'd0, ir_valid}, 32'd1);
  endtask

  // One instruction: push its expectation, then drive controls only on the final EXEC cycle.
  task automatic run_instr(input logic [1:0] b, input logic p, input logic z,
                           input logic [7:0] ra, input logic [7:0] cd, input int nst);
    exp_t e;
    e.pc     = pc_model;
    e.ir     = mem[pc_model];
    e.nstall = nst;
    model_next(int'(pc_model), int'(b), int'(p), int'(z), int'(ra), int'(cd), e.nxt, e.taken);
    exp_q.push_back(e);
    wait_exec();
    repeat (nst) begin
      drive_garbage();
      stall = 1'b1;
      tick();
    end
    bs = b; ps = p; zero = z; reg_a_data = ra; const_data = cd; stall = 1'b0;
    tick();
    pc_model = e.nxt;
    if (e.taken) taken_cnt++;
    drive_garbage();
    stall = 1'($urandom_range(0, 1));
  endtask

  task automatic jump(input logic [7:0] target);
    run_instr(2'b11, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), target, 0);
  endtask

  task automatic check_reset_state();
    check("rst_pc", {24'd0, pc}, 32'h00);
    check("rst_ir", {15'd0, ir}, 32'h0);
    check("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
    check("rst_imem_rd", {31'd0, imem_rd}, 32'd0);
    check("rst_branch_taken", {31'd0, branch_taken}, 32'd0);
`ifdef FETCH_BRANCH_COUNT_EN
    check("rst_branch_count", {16'd0, branch_count}, 32'd0);
`endif
  endtask

  // Monitor: compares DUT activity against the scoreboard on every falling edge.
  initial begin
    logic prev_v;
    int   low_cnt;
    int   high_cnt;
    exp_t e;
    prev_v = 1'b0; low_cnt = 0; high_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0; low_cnt = 0; high_cnt = 0;
      end else begin
        if (!ir_valid && prev_v) begin
          check("sb_occupancy_exit", {31'd0, exp_q.size() > 0}, 32'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("next_pc", {24'd0, pc}, {24'd0, e.nxt});
            check("branch_taken", {31'd0, branch_taken}, {31'd0, e.taken});
            check("exec_cycles", high_cnt, e.nstall + 1);
          end
          low_cnt = 0; high_cnt = 0;
        end else begin
          check("no_stray_taken", {31'd0, branch_taken}, 32'd0);
        end
        if (ir_valid) begin
          check("sb_occupancy_exec", {31'd0, exp_q.size() > 0}, 32'd1);
          if (!prev_v) check("fetch_latency", low_cnt, 2);
          high_cnt++;
          if (exp_q.size() > 0) begin
            check("exec_pc", {24'd0, pc}, {24'd0, exp_q[0].pc});
            check("exec_ir", {15'd0, ir}, {15'd0, exp_q[0].ir});
            if (!prev_v) check("pc_plus1", {24'd0, pc_plus1}, (int'(exp_q[0].pc) + 1) % 256);
          end
        end else begin
          low_cnt++;
        end
        if (imem_rd && exp_q.size() > 0) begin
          check("imem_addr", {24'd0, imem_addr}, {24'd0, exp_q[0].pc});
        end
        prev_v = ir_valid;
      end
    end
  end

  initial begin
    n_checks = 0; n_fail = 0; taken_cnt = 0; pc_model = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 17'($urandom_range(0, 32'h1FFFF));
    for (int i = 0; i < 4; i++) mem[i] = 17'h0F2C8;
    rst = 1'b1; stall = 1'b0;
    bs = 2'b00; ps = 1'b0; zero = 1'b0; reg_a_data = 8'h00; const_data = 8'h00;
    repeat (3) tick();
    check_reset_state();
    rst = 1'b0;

    // Free run through the ADD block.
    for (int i = 0; i < 4; i++) run_instr(2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 0);

    // Directed branch cases.
    jump(8'h10);
    run_instr(2'b01, 1'b0, 1'b1, 8'h00, 8'h05, 0);
    jump(8'h10);
    run_instr(2'b01, 1'b0, 1'b0, 8'h00, 8'h05, 0);
    jump(8'h20);
    run_instr(2'b11, 1'b1, 1'b0, 8'h00, 8'hFE, 0);
    jump(8'h40);
    run_instr(2'b11, 1'b0, 1'b0, 8'h00, 8'h80, 1);
    jump(8'h40);
    run_instr(2'b10, 1'b0, 1'b0, 8'h33, 8'h00, 0);
    jump(8'h30);
    run_instr(2'b11, 1'b0, 1'b0, 8'h00, 8'h31, 0);
    jump(8'hFF);
    run_instr(2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 4);

    // Randomized instructions with random stalls.
    for (int i = 0; i < 40; i++) begin
      run_instr(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), $urandom_range(0, 3));
    end
`ifdef FETCH_BRANCH_COUNT_EN
    check("branch_count_random", {16'd0, branch_count}, taken_cnt);
`endif

    // Reset in EXEC with a pending jump to 8'h80.
    jump(8'h40);
    begin
      exp_t d;
      d.pc = pc_model; d.ir = mem[pc_model]; d.nxt = 8'h80; d.taken = 1'b1; d.nstall = 0;
      exp_q.push_back(d);
    end
    wait_exec();
    bs = 2'b11; ps = 1'b0; const_data = 8'h80; stall = 1'b0; rst = 1'b1;
    tick();
    check_reset_state();
    rst = 1'b0;
    #1;
    check("post_rst_imem_rd", {31'd0, imem_rd}, 32'd1);
    check("post_rst_imem_addr", {24'd0, imem_addr}, 32'h00);
    exp_q.delete();
    pc_model = 8'h00;
    taken_cnt = 0;

    // Three taken and two not-taken branches after reset.
    jump(8'h10);
    run_instr(2'b01, 1'b0, 1'b1, 8'h00, 8'h05, 0);
    run_instr(2'b01, 1'b0, 1'b0, 8'h00, 8'h05, 0);
    run_instr(2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 2);
    run_instr(2'b10, 1'b0, 1'b0, 8'h30, 8'h00, 0);
    repeat (2) tick();
`ifdef FETCH_BRANCH_COUNT_EN
    check("branch_count_3", {16'd0, branch_count}, 32'd3);
`endif
    check("final_pc", {24'd0, pc}, 32'h30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
